// File: rtl/por_seq_pkg.sv
// Shared types and constants for the POR release sequencer.
// Holds the FSM state encoding, default parameters and a width helper.
package por_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGE_GAP   = 8;
    localparam int DEF_ACK_TIMEOUT = 255;

    // Width of a counter that must hold values 0..val inclusive.
    function automatic int cnt_w(input int val);
        if (val < 1) begin
            return 1;
        end
        return $clog2(val + 1);
    endfunction

endpackage

// File: rtl/por_sync.sv
// Flop-chain synchroniser for the asynchronous por_n input.
// Resets to 0 so POR is seen as asserted until proven otherwise.
import por_seq_pkg::*;

module por_sync #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the asynchronous level through the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/por_release_sequencer.sv
// Qualifies the POR generator output and releases reset domains in order,
// waiting for each domain's ack and flagging a sticky fault on timeout.
import por_seq_pkg::*;

module por_release_sequencer #(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          por_n,
    input  logic [NUM_STAGES-1:0]         stage_ack,
    output logic [NUM_STAGES-1:0]         stage_rst_n,
    output logic                          all_ready,
    output logic                          fault,
    output logic [$clog2(NUM_STAGES)-1:0] fault_stage
);

    localparam int IDX_W  = $clog2(NUM_STAGES);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int GAP_W  = cnt_w(STAGE_GAP);
    localparam int TMO_W  = cnt_w(ACK_TIMEOUT);
    localparam int CNT_W  = (GAP_W > TMO_W) ? GAP_W : TMO_W;

    // The hold transition fires on the edge the count reaches its target,
    // so the RELEASE edge lands exactly one edge after the last hold cycle.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);

    logic                  w_por_s;
    state_e                r_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic                  r_all_ready;
    logic                  r_fault;
    logic [IDX_W-1:0]      r_fault_stage;

    por_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_por_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (por_n),
        .o_sync  (w_por_s)
    );

    // Sequencing FSM; gap and ack timer share r_cnt since never both live.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage_rst_n <= '0;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else if (!w_por_s) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage_rst_n <= '0;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt <= HOLD_FULL;
                        r_idx      <= '0;
                        r_state    <= ST_RELEASE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    r_stage_rst_n[r_idx] <= 1'b1;
                    r_cnt                <= '0;
                    r_state              <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (stage_ack[r_idx]) begin
                        r_cnt <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_all_ready <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else if (r_cnt == TMO_LAST) begin
                        r_fault       <= 1'b1;
                        r_fault_stage <= r_idx;
                        r_stage_rst_n <= '0;
                        r_state       <= ST_FAULT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign stage_rst_n = r_stage_rst_n;
    assign all_ready   = r_all_ready;
    assign fault       = r_fault;
    assign fault_stage = r_fault_stage;

endmodule

// File: tb/tb_por_release_sequencer.sv
// Self-checking bench for por_release_sequencer: timestamp-based model,
// latency table, directed corner sequences and randomized traffic.
module tb_por_release_sequencer;

    localparam int N    = 4;
    localparam int SYN  = 2;
    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int TMO  = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         por_n;
    logic [N-1:0] stage_ack;
    logic [N-1:0] stage_rst_n;
    logic         all_ready;
    logic         fault;
    logic [1:0]   fault_stage;

    por_release_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .por_n       (por_n),
        .stage_ack   (stage_ack),
        .stage_rst_n (stage_rst_n),
        .all_ready   (all_ready),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // model state: event timestamps rather than counters
    bit [SYN-1:0] m_sync;
    bit [N-1:0]   m_rst;
    bit           m_ready;
    bit           m_fault;
    bit [1:0]     m_fst;
    bit           in_hold;
    int           run;
    int           rel_due;
    int           rel_at;
    int           cur;
    int           nxt;

    // environment ack driver
    bit           auto_ack;
    int           ack_lat;
    bit [N-1:0]   never;
    int           rel_seen[N];

    typedef struct {
        int   lat;
        int   exp_edge;
        logic exp_fault;
        int   exp_fst;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at edge %0d", nm, got, exp, n);
        end
    endtask

    task automatic model_step();
        bit ps;
        if (!rst_n) begin
            m_sync = '0; m_rst = '0; m_ready = 0; m_fault = 0; m_fst = 0;
            in_hold = 1; run = 0; rel_due = -1; cur = -1; nxt = 0;
        end else begin
            ps = m_sync[SYN-1];
            m_sync = {m_sync[SYN-2:0], por_n};
            if (!ps) begin
                m_rst = '0; m_ready = 0; m_fault = 0;
                in_hold = 1; run = 0; rel_due = -1; cur = -1; nxt = 0;
            end else if (in_hold) begin
                run++;
                if (run == HOLD) begin
                    in_hold = 0; rel_due = n + 1; nxt = 0;
                end
            end else if (rel_due == n) begin
                m_rst[nxt] = 1'b1; cur = nxt; rel_at = n; rel_due = -1;
            end else if (cur >= 0) begin
                if (stage_ack[cur]) begin
                    if (cur == N - 1) m_ready = 1;
                    else begin
                        rel_due = n + GAP + 1; nxt = cur + 1;
                    end
                    cur = -1;
                end else if (n - rel_at == TMO + 1) begin
                    m_fault = 1; m_fst = 2'(cur); m_rst = '0; cur = -1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        model_step();
        #1;
        chk("stage_rst_n", 32'(stage_rst_n), 32'(m_rst));
        chk("all_ready", 32'(all_ready), 32'(m_ready));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_stage", 32'(fault_stage), 32'(m_fst));
        for (int i = 0; i < N; i++) begin
            if (!stage_rst_n[i]) rel_seen[i] = -1;
            else if (rel_seen[i] < 0) rel_seen[i] = n;
        end
        if (auto_ack) begin
            for (int i = 0; i < N; i++)
                stage_ack[i] = rel_seen[i] >= 0 && !never[i] &&
                               (n - rel_seen[i] >= ack_lat - 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; por_n = 0; stage_ack = '0;
        auto_ack = 0; never = '0; ack_lat = 1;
        repeat (3) tick();
        rst_n = 1;
        tick();
    endtask

    int n0, got, r2, cnt;

    initial begin
        vecs[0] = '{1,   50,   1'b0, 0};
        vecs[1] = '{3,   58,   1'b0, 0};
        vecs[2] = '{10,  86,   1'b0, 0};
        vecs[3] = '{256, 1070, 1'b0, 0};
        vecs[4] = '{257, 275,  1'b1, 0};
        for (int i = 0; i < N; i++) rel_seen[i] = -1;

        // power-up reset values
        rst_n = 0; por_n = 0; stage_ack = '0;
        auto_ack = 0; never = '0; ack_lat = 1;
        repeat (5) tick();
        chk("reset_rst_n", 32'(stage_rst_n), 0);
        chk("reset_flags", 32'({all_ready, fault, fault_stage}), 0);
        rst_n = 1;
        repeat (4) tick();

        // ack-latency table
        foreach (vecs[v]) begin
            do_reset();
            auto_ack = 1; ack_lat = vecs[v].lat;
            por_n = 1; n0 = n; got = -1;
            for (int k = 0; k < 1500 && got < 0; k++) begin
                tick();
                if (stage_rst_n[0] && rel_seen[0] == n && n - n0 != 19)
                    chk("first_release", n - n0, 19);
                if (all_ready || fault) got = n - n0;
            end
            chk("lat_edge", got, vecs[v].exp_edge);
            chk("lat_fault", 32'(fault), 32'(vecs[v].exp_fault));
            chk("lat_fstage", 32'(fault_stage), vecs[v].exp_fst);
        end

        // glitch low during hold restarts the count
        do_reset();
        por_n = 1; repeat (10) tick();
        por_n = 0; tick();
        por_n = 1; n0 = n; got = -1;
        for (int k = 0; k < 60 && got < 0; k++) begin
            tick();
            if (stage_rst_n[0]) got = n - n0;
        end
        chk("glitch_release", got, 19);

        // timeout on stage 2, sticky until a POR pulse
        do_reset();
        auto_ack = 1; ack_lat = 3; never = 4'b0100;
        por_n = 1; r2 = -1; got = -1;
        for (int k = 0; k < 700 && got < 0; k++) begin
            tick();
            if (stage_rst_n[2] && r2 < 0) r2 = n;
            if (fault) got = n;
        end
        chk("tmo_edge", got - r2, 256);
        chk("tmo_stage", 32'(fault_stage), 2);
        chk("tmo_rst_n", 32'(stage_rst_n), 0);
        repeat (20) tick();
        chk("tmo_sticky", 32'(fault), 1);
        chk("tmo_held", 32'(stage_rst_n), 0);
        por_n = 0; tick();
        por_n = 1; never = '0;
        repeat (2) tick();
        chk("tmo_clear", 32'(fault), 0);
        for (int k = 0; k < 200 && !all_ready; k++) tick();
        chk("tmo_recover", 32'(all_ready), 1);

        // POR drop in GAP after stage 1
        do_reset();
        auto_ack = 1; ack_lat = 2;
        por_n = 1;
        for (int k = 0; k < 100 && rel_seen[1] < 0; k++) tick();
        repeat (4) tick();
        por_n = 0; cnt = 0;
        for (int k = 0; k < 10 && stage_rst_n != 0; k++) begin
            tick(); cnt++;
        end
        chk("midpor_edges", cnt, 3);
        repeat (5) tick();
        chk("midpor_ready", 32'(all_ready), 0);
        por_n = 1; n0 = n; got = -1;
        for (int k = 0; k < 60 && got < 0; k++) begin
            tick();
            if (stage_rst_n != 0) got = n - n0;
        end
        chk("midpor_restart", got, 19);
        chk("midpor_stage0", 32'(stage_rst_n), 1);

        // acks high from reset, then reset in DONE
        do_reset();
        stage_ack = '1;
        por_n = 1; n0 = n; got = -1;
        for (int k = 0; k < 100 && got < 0; k++) begin
            tick();
            if (all_ready) got = n - n0;
        end
        chk("early_ack", got, 50);
        rst_n = 0; tick();
        chk("rst_done_rst_n", 32'(stage_rst_n), 0);
        chk("rst_done_flags", 32'({all_ready, fault, fault_stage}), 0);
        rst_n = 1;

        // stray ack on another stage is ignored
        do_reset();
        por_n = 1;
        for (int k = 0; k < 40 && !stage_rst_n[0]; k++) tick();
        stage_ack = 4'b1000;
        repeat (10) tick();
        chk("stray_rst_n", 32'(stage_rst_n), 1);
        chk("stray_ready", 32'(all_ready), 0);
        stage_ack = '1;
        for (int k = 0; k < 60 && !all_ready; k++) tick();
        chk("stray_done", 32'(all_ready), 1);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 5000; k++) begin
            if (por_n) begin
                if ($urandom_range(199) == 0) por_n = 0;
            end else if ($urandom_range(3) == 0) por_n = 1;
            if ($urandom_range(9) == 0)
                stage_ack[$urandom_range(N-1)] ^= 1'b1;
            rst_n = ($urandom_range(999) != 0);
            tick();
        end
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
